// File: rtl/mux_pkg.sv
// Shared types and helpers for the scanned N:1 multiplexer.
package mux_pkg;

   typedef int unsigned sel_width_t;

   typedef enum logic {
      MODE_MANUAL = 1'b0,
      MODE_AUTO   = 1'b1
   } mode_e;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(value)) r++;
      return r;
   endfunction

endpackage

// File: rtl/mux_scan_counter.sv
// Auto-scan prescaler, wrap-around channel stepping and tick generation.
// Optional reverse scanning with a dir input when MUX_SCAN_REVERSE_EN is defined.
module mux_scan_counter
   import mux_pkg::*;
#(
   parameter int unsigned CHANNELS = 4,
   parameter int unsigned SCAN_DIV = 50_000_000,
   parameter sel_width_t  SEL_W    = clog2(CHANNELS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             auto_en,
   input  logic             hold,
`ifdef MUX_SCAN_REVERSE_EN
   input  logic             dir,
`endif
   input  logic [SEL_W-1:0] sel_cur,
   output logic             step,
   output logic [SEL_W-1:0] step_sel,
   output logic             tick
);

   localparam int unsigned      PRE_W    = (SCAN_DIV > 1) ? clog2(SCAN_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
   localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(CHANNELS - 1);

   logic [PRE_W-1:0] presc_q;
   logic [PRE_W-1:0] presc_d;
   logic             down;

`ifdef MUX_SCAN_REVERSE_EN
   assign down = dir;
`else
   assign down = 1'b0;
`endif

   always_comb begin
      step    = auto_en && !hold && (presc_q == PRE_LAST);
      presc_d = presc_q;
      if (!auto_en) begin
         presc_d = '0;
      end else if (!hold) begin
         presc_d = step ? '0 : presc_q + 1'b1;
      end
      // dir only matters on the wrap cycle because step_sel is used only then
      if (down) begin
         step_sel = (sel_cur == '0) ? SEL_LAST : sel_cur - 1'b1;
      end else begin
         step_sel = (sel_cur == SEL_LAST) ? '0 : sel_cur + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         presc_q <= '0;
         tick    <= 1'b0;
      end else begin
         presc_q <= presc_d;
         tick    <= step;
      end
   end

endmodule

// File: rtl/mux_scan_nto1.sv
// Registered N-channel, W-bit mux with manual select or auto-scan sequencing.
// Define MUX_SCAN_REVERSE_EN to add the dir input for reverse scanning.
module mux_scan_nto1
   import mux_pkg::*;
#(
   parameter  int unsigned WIDTH    = 4,
   parameter  int unsigned CHANNELS = 4,
   parameter  int unsigned SCAN_DIV = 50_000_000,
   localparam sel_width_t  SEL_W    = clog2(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [CHANNELS*WIDTH-1:0] x_bus,
   input  logic                      mode,
   input  logic [SEL_W-1:0]          sel_in,
   input  logic                      hold,
`ifdef MUX_SCAN_REVERSE_EN
   input  logic                      dir,
`endif
   output logic [WIDTH-1:0]          m,
   output logic [SEL_W-1:0]          sel_out,
   output logic                      tick,
   output logic                      sel_err
);

   logic [SEL_W-1:0] sel_q;
   logic [SEL_W-1:0] sel_d;
   logic [SEL_W-1:0] step_sel;
   logic             step;
   logic             err_d;
   logic             auto_en;
   logic             in_range;
   logic [WIDTH-1:0] word;

   assign auto_en  = (mode_e'(mode) == MODE_AUTO);
   assign in_range = 32'(sel_in) < CHANNELS;

   mux_scan_counter #(
      .CHANNELS (CHANNELS),
      .SCAN_DIV (SCAN_DIV),
      .SEL_W    (SEL_W)
   ) u_counter (
      .clk      (clk),
      .rst_n    (rst_n),
      .auto_en  (auto_en),
      .hold     (hold),
`ifdef MUX_SCAN_REVERSE_EN
      .dir      (dir),
`endif
      .sel_cur  (sel_q),
      .step     (step),
      .step_sel (step_sel),
      .tick     (tick)
   );

   always_comb begin
      sel_d = sel_q;
      err_d = 1'b0;
      if (!auto_en) begin
         if (in_range) begin
            sel_d = sel_in;
         end else begin
            err_d = 1'b1;
         end
      end else if (step) begin
         sel_d = step_sel;
      end
   end

   // Compare-based select keeps non-power-of-two channel counts in range.
   always_comb begin
      word = '0;
      for (int unsigned k = 0; k < CHANNELS; k++) begin
         if (32'(sel_q) == k) word = x_bus[k*WIDTH +: WIDTH];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sel_q   <= '0;
         sel_err <= 1'b0;
         m       <= '0;
      end else begin
         sel_q   <= sel_d;
         sel_err <= err_d;
         m       <= word;
      end
   end

   assign sel_out = sel_q;

endmodule
